// File: rtl/jzjpcc_decode_hazard_controller.sv
// jzjpcc_decode_hazard_controller
//
// Pipeline sequencer for the fetch and decode stages of the pipelined core.
// Every cycle it decides whether the instruction sitting in decode advances
// into execute, is held where it is, or is replaced by a bubble. The inputs
// that drive the decision are:
// - load-use hazards against the load currently in execute
// - control-flow redirects resolved by decode's next-PC logic
// - data-memory waits, which freeze the whole pipe
// - ECALL/EBREAK halts, released by an external resume pulse
// A saturating counter of stalled-decode cycles is kept for debug.
//
// Parameters:
//   REDIRECT_FLUSH_CYCLES  fetch latency; number of cycles fetch output is
//                          discarded after a redirect (1..3)
//   COUNT_WIDTH            width of the stall-cycle counter
//
// Ports:
//   clock            in   core clock, rising edge
//   reset_n          in   asynchronous active-low reset
//   decode_valid     in   decode holds a real instruction
//   decode_rs1       in   rs1 field of the decode instruction
//   decode_rs1_used  in   decode instruction reads rs1
//   decode_rs2       in   rs2 field of the decode instruction
//   decode_rs2_used  in   decode instruction reads rs2
//   execute_is_load  in   execute stage holds a LOAD
//   execute_rd       in   destination register of the execute instruction
//   redirect_request in   decode resolved JAL/JALR/taken branch
//   mem_busy         in   memory stage waiting on data memory
//   halt_request     in   decode holds ECALL/EBREAK
//   resume           in   external debug resume pulse
//   stall_fetch      out  hold PC and fetch register
//   stall_decode     out  hold decode register
//   bubble_execute   out  load a NOP into execute
//   flush_fetch      out  discard the instruction arriving from fetch
//   take_redirect    out  PC mux selects the decode-computed target
//   halted           out  core halted
//   stall_count      out  saturating count of cycles with stall_decode=1

module jzjpcc_decode_hazard_controller #(
    parameter int REDIRECT_FLUSH_CYCLES = 1,
    parameter int COUNT_WIDTH           = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   decode_valid,
    input  logic [4:0]             decode_rs1,
    input  logic                   decode_rs1_used,
    input  logic [4:0]             decode_rs2,
    input  logic                   decode_rs2_used,
    input  logic                   execute_is_load,
    input  logic [4:0]             execute_rd,
    input  logic                   redirect_request,
    input  logic                   mem_busy,
    input  logic                   halt_request,
    input  logic                   resume,
    output logic                   stall_fetch,
    output logic                   stall_decode,
    output logic                   bubble_execute,
    output logic                   flush_fetch,
    output logic                   take_redirect,
    output logic                   halted,
    output logic [COUNT_WIDTH-1:0] stall_count
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        REDIRECT = 2'd2,
        HALT     = 2'd3
    } state_t;

    // The redirect cycle itself discards one fetch slot; the counter holds
    // how many further slots still need discarding.
    localparam logic [1:0] FLUSH_LOAD      = 2'(REDIRECT_FLUSH_CYCLES - 1);
    localparam bit         NEEDS_FLUSH_ST  = (REDIRECT_FLUSH_CYCLES > 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    state_t     state;
    state_t     next_state;
    logic [1:0] flush_cnt;
    logic [1:0] next_flush_cnt;

    logic       hazard;
    logic       rs1_match;
    logic       rs2_match;

    logic       sf_c;
    logic       sd_c;
    logic       be_c;
    logic       ff_c;
    logic       tr_c;
    logic       hl_c;

    // Load-use detection: x0 is hard-wired zero, so a load targeting it
    // can never produce a value decode needs to wait for.
    always_comb begin
        rs1_match = decode_rs1_used && (decode_rs1 == execute_rd);
        rs2_match = decode_rs2_used && (decode_rs2 == execute_rd);
        hazard    = decode_valid && execute_is_load && (execute_rd != 5'd0)
                    && (rs1_match || rs2_match);
    end

    // Next-state and raw output decode. MEM_WAIT shares the RUN decision
    // tree: once mem_busy drops the normal rules apply in the same cycle,
    // so leaving the wait costs no extra cycle. Inside RUN the order of the
    // if-chain is the priority order; the hazard check sits above the
    // redirect check so that take_redirect can never coincide with a stall.
    always_comb begin
        next_state     = state;
        next_flush_cnt = flush_cnt;
        sf_c           = 1'b0;
        sd_c           = 1'b0;
        be_c           = 1'b0;
        ff_c           = 1'b0;
        tr_c           = 1'b0;
        hl_c           = 1'b0;

        case (state)
            RUN, MEM_WAIT: begin
                if (mem_busy) begin
                    sf_c       = 1'b1;
                    sd_c       = 1'b1;
                    next_state = MEM_WAIT;
                end else if (decode_valid && halt_request) begin
                    sf_c       = 1'b1;
                    sd_c       = 1'b1;
                    be_c       = 1'b1;
                    next_state = HALT;
                end else if (hazard) begin
                    sf_c       = 1'b1;
                    sd_c       = 1'b1;
                    be_c       = 1'b1;
                    next_state = RUN;
                end else if (decode_valid && redirect_request) begin
                    tr_c           = 1'b1;
                    ff_c           = 1'b1;
                    next_flush_cnt = FLUSH_LOAD;
                    next_state     = NEEDS_FLUSH_ST ? REDIRECT : RUN;
                end else begin
                    next_state = RUN;
                end
            end

            // Wrong-path fetches keep arriving until the fetch latency has
            // drained. A memory wait freezes the drain without losing it.
            REDIRECT: begin
                ff_c = 1'b1;
                if (mem_busy) begin
                    sf_c = 1'b1;
                    sd_c = 1'b1;
                end else if (flush_cnt <= 2'd1) begin
                    next_flush_cnt = 2'd0;
                    next_state     = RUN;
                end else begin
                    next_flush_cnt = flush_cnt - 2'd1;
                end
            end

            // Halted: the ECALL/EBREAK stays parked in decode and execute is
            // fed bubbles. On resume decode is released so the halting
            // instruction is consumed as a bubble rather than re-executed.
            HALT: begin
                sf_c = 1'b1;
                sd_c = !resume;
                be_c = 1'b1;
                hl_c = 1'b1;
                if (resume) begin
                    next_state = RUN;
                end
            end

            default: begin
                next_state     = RUN;
                next_flush_cnt = 2'd0;
            end
        endcase
    end

    // Outputs are forced low for as long as reset is held, independent of
    // whatever the other inputs are doing.
    always_comb begin
        stall_fetch    = reset_n && sf_c;
        stall_decode   = reset_n && sd_c;
        bubble_execute = reset_n && be_c;
        flush_fetch    = reset_n && ff_c;
        take_redirect  = reset_n && tr_c;
        halted         = reset_n && hl_c;
    end

    // State and flush counter. Reset abandons any partial flush.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= RUN;
            flush_cnt <= 2'd0;
        end else begin
            state     <= next_state;
            flush_cnt <= next_flush_cnt;
        end
    end

    // Debug stall counter: sticks at all-ones instead of wrapping so a
    // long-running stall storm is still visible.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_count <= '0;
        end else if (stall_decode && (stall_count != '1)) begin
            stall_count <= stall_count + COUNT_ONE;
        end
    end

endmodule

// File: tb/tb_jzjpcc_decode_hazard_controller.sv
// tb_jzjpcc_decode_hazard_controller
//
// Drives the decode hazard controller with directed scenarios and random
// traffic. The driver computes each cycle's expected response from a
// behavioural model and queues it; an independent monitor pops and compares
// the observed response once per cycle on the falling edge.

module tb_jzjpcc_decode_hazard_controller;

    localparam int FLUSH_N = 2;
    localparam int CW      = 16;
    localparam int CMAX    = (1 << CW) - 1;

    typedef struct {
        bit       rst;
        bit       dv;
        bit [4:0] rs1;
        bit       rs1_used;
        bit [4:0] rs2;
        bit       rs2_used;
        bit       is_load;
        bit [4:0] rd;
        bit       redirect;
        bit       mem_busy;
        bit       halt;
        bit       resume;
    } stim_t;

    typedef struct {
        bit       sf;
        bit       sd;
        bit       be;
        bit       ff;
        bit       tr;
        bit       hl;
        int       cnt;
        int       cycle;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          decode_valid;
    logic [4:0]    decode_rs1;
    logic          decode_rs1_used;
    logic [4:0]    decode_rs2;
    logic          decode_rs2_used;
    logic          execute_is_load;
    logic [4:0]    execute_rd;
    logic          redirect_request;
    logic          mem_busy;
    logic          halt_request;
    logic          resume;
    logic          stall_fetch;
    logic          stall_decode;
    logic          bubble_execute;
    logic          flush_fetch;
    logic          take_redirect;
    logic          halted;
    logic [CW-1:0] stall_count;

    jzjpcc_decode_hazard_controller #(
        .REDIRECT_FLUSH_CYCLES(FLUSH_N),
        .COUNT_WIDTH(CW)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .decode_valid(decode_valid),
        .decode_rs1(decode_rs1),
        .decode_rs1_used(decode_rs1_used),
        .decode_rs2(decode_rs2),
        .decode_rs2_used(decode_rs2_used),
        .execute_is_load(execute_is_load),
        .execute_rd(execute_rd),
        .redirect_request(redirect_request),
        .mem_busy(mem_busy),
        .halt_request(halt_request),
        .resume(resume),
        .stall_fetch(stall_fetch),
        .stall_decode(stall_decode),
        .bubble_execute(bubble_execute),
        .flush_fetch(flush_fetch),
        .take_redirect(take_redirect),
        .halted(halted),
        .stall_count(stall_count)
    );

    always #5 clock = ~clock;

    exp_t  expq[$];
    int    total = 0;
    int    bad   = 0;
    int    cycleNo = 0;
    stim_t s;

    // Behavioural model: the machine is either halted, draining wrong-path
    // fetches (flushLeft > 0), or running normally.
    bit    mHalted    = 1'b0;
    int    mFlushLeft = 0;
    int    mCount     = 0;

    function automatic stim_t idle();
        stim_t r;
        r = '{default: 0};
        return r;
    endfunction

    function automatic bit isHazard(input stim_t x);
        bit reads;
        reads = (x.rs1_used && x.rs1 == x.rd) || (x.rs2_used && x.rs2 == x.rd);
        return x.dv && x.is_load && (x.rd != 0) && reads;
    endfunction

    task automatic modelStep(input stim_t x, output exp_t e);
        e = '{default: 0};
        e.cycle = cycleNo;
        if (x.rst) begin
            mHalted    = 1'b0;
            mFlushLeft = 0;
            mCount     = 0;
            e.cnt      = 0;
            return;
        end
        e.cnt = mCount;
        if (mHalted) begin
            e.sf = 1; e.be = 1; e.hl = 1;
            e.sd = !x.resume;
            if (x.resume) mHalted = 1'b0;
        end else if (mFlushLeft > 0) begin
            e.ff = 1;
            if (x.mem_busy) begin
                e.sf = 1; e.sd = 1;
            end else begin
                mFlushLeft = mFlushLeft - 1;
            end
        end else if (x.mem_busy) begin
            e.sf = 1; e.sd = 1;
        end else if (x.dv && x.halt) begin
            e.sf = 1; e.sd = 1; e.be = 1;
            mHalted = 1'b1;
        end else if (isHazard(x)) begin
            e.sf = 1; e.sd = 1; e.be = 1;
        end else if (x.dv && x.redirect) begin
            e.tr = 1; e.ff = 1;
            mFlushLeft = FLUSH_N - 1;
        end
        if (e.sd && mCount < CMAX) mCount = mCount + 1;
    endtask

    // One cycle of stimulus: inputs change just after the rising edge and
    // the expected response for this cycle is queued for the monitor.
    task automatic applyStimulus(input stim_t x);
        exp_t e;
        @(posedge clock);
        #1;
        cycleNo          = cycleNo + 1;
        reset_n          = !x.rst;
        decode_valid     = x.dv;
        decode_rs1       = x.rs1;
        decode_rs1_used  = x.rs1_used;
        decode_rs2       = x.rs2;
        decode_rs2_used  = x.rs2_used;
        execute_is_load  = x.is_load;
        execute_rd       = x.rd;
        redirect_request = x.redirect;
        mem_busy         = x.mem_busy;
        halt_request     = x.halt;
        resume           = x.resume;
        modelStep(x, e);
        expq.push_back(e);
    endtask

    task automatic checkOutput(input string name, input int cyc, input int got, input int want);
        total = total + 1;
        if (got != want) begin
            bad = bad + 1;
            $display("[TB] FAIL %s cycle=%0d got=%0d want=%0d", name, cyc, got, want);
        end
    endtask

    // Monitor: the DUT presents a response every cycle; compare it on the
    // falling edge against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                checkOutput("stall_fetch",    e.cycle, int'(stall_fetch),    int'(e.sf));
                checkOutput("stall_decode",   e.cycle, int'(stall_decode),   int'(e.sd));
                checkOutput("bubble_execute", e.cycle, int'(bubble_execute), int'(e.be));
                checkOutput("flush_fetch",    e.cycle, int'(flush_fetch),    int'(e.ff));
                checkOutput("take_redirect",  e.cycle, int'(take_redirect),  int'(e.tr));
                checkOutput("halted",         e.cycle, int'(halted),         int'(e.hl));
                checkOutput("stall_count",    e.cycle, int'(stall_count),    e.cnt);
            end
        end
    end

    initial begin
        reset_n          = 1'b0;
        decode_valid     = 1'b0;
        decode_rs1       = '0;
        decode_rs1_used  = 1'b0;
        decode_rs2       = '0;
        decode_rs2_used  = 1'b0;
        execute_is_load  = 1'b0;
        execute_rd       = '0;
        redirect_request = 1'b0;
        mem_busy         = 1'b0;
        halt_request     = 1'b0;
        resume           = 1'b0;

        // Reset for three cycles, then idle.
        s = idle(); s.rst = 1;
        repeat (3) applyStimulus(s);
        s = idle();
        repeat (2) applyStimulus(s);

        // Load-use on rs2, then the load has moved on.
        s = idle(); s.dv = 1; s.is_load = 1; s.rd = 5; s.rs2 = 5; s.rs2_used = 1;
        applyStimulus(s);
        s.is_load = 0;
        applyStimulus(s);

        // A load to x0 never stalls.
        s = idle(); s.dv = 1; s.is_load = 1; s.rd = 0; s.rs1 = 0; s.rs1_used = 1;
        applyStimulus(s);

        // Plain redirect, then the wrong-path slots drain.
        s = idle(); s.dv = 1; s.redirect = 1;
        applyStimulus(s);
        s = idle();
        repeat (3) applyStimulus(s);

        // Redirect blocked by a load-use hazard for two cycles.
        s = idle(); s.dv = 1; s.redirect = 1; s.is_load = 1; s.rd = 7; s.rs1 = 7; s.rs1_used = 1;
        repeat (2) applyStimulus(s);
        s.is_load = 0;
        applyStimulus(s);
        s = idle();
        repeat (3) applyStimulus(s);

        // Memory wait during the redirect drain.
        s = idle(); s.dv = 1; s.redirect = 1;
        applyStimulus(s);
        s = idle(); s.mem_busy = 1;
        repeat (4) applyStimulus(s);
        s = idle();
        repeat (3) applyStimulus(s);

        // Halt, sit halted (memory waits ignored), resume, run on.
        s = idle(); s.dv = 1; s.halt = 1;
        applyStimulus(s);
        for (int i = 0; i < 10; i++) begin
            s = idle(); s.dv = 1; s.halt = 1; s.mem_busy = (i % 3 == 0);
            applyStimulus(s);
        end
        s = idle(); s.dv = 1; s.halt = 1; s.resume = 1;
        applyStimulus(s);
        s = idle();
        repeat (2) applyStimulus(s);

        // Random traffic with small register indices so hazards are common.
        for (int i = 0; i < 3000; i++) begin
            s = idle();
            s.rst      = ($urandom_range(0, 99) == 0);
            s.dv       = ($urandom_range(0, 3) != 0);
            s.rs1      = 5'($urandom_range(0, 3));
            s.rs1_used = $urandom_range(0, 1);
            s.rs2      = 5'($urandom_range(0, 3));
            s.rs2_used = $urandom_range(0, 1);
            s.is_load  = ($urandom_range(0, 2) == 0);
            s.rd       = 5'($urandom_range(0, 3));
            s.redirect = ($urandom_range(0, 3) == 0);
            s.mem_busy = ($urandom_range(0, 6) == 0);
            s.halt     = ($urandom_range(0, 19) == 0);
            s.resume   = ($urandom_range(0, 4) == 0);
            applyStimulus(s);
        end

        // Saturation: clean start, then a very long memory wait.
        s = idle(); s.rst = 1;
        applyStimulus(s);
        s = idle(); s.mem_busy = 1;
        repeat (65540) applyStimulus(s);
        s = idle();
        repeat (2) applyStimulus(s);

        // Reset from a mid-redirect position clears everything.
        s = idle(); s.dv = 1; s.redirect = 1;
        applyStimulus(s);
        s = idle(); s.rst = 1;
        applyStimulus(s);
        s = idle();
        repeat (2) applyStimulus(s);

        for (int i = 0; i < 5 && expq.size() != 0; i++) @(negedge clock);
        if (expq.size() != 0) begin
            bad = bad + 1;
            $display("[TB] FAIL drain got=%0d want=0 pending", expq.size());
        end
        @(posedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
